// File: rtl/mxint8_quantize_pkg.sv
// Shared widths, state encoding and exponent helper for the MXINT8 quantizer.
// Optional feature macro used by the datapath: MXINT8_QUANT_RNE_EN.
package mxint8_quantize_pkg;

  localparam int FLOAT32_WIDTH        = 32;
  localparam int DEF_BLOCK_SIZE       = 32;
  localparam int DEF_SCALE_WIDTH      = 8;
  localparam int DEF_ELEMENT_WIDTH    = 8;
  // m (24-bit significand) lands in the 7-bit magnitude when eff_e == S
  localparam int QUANT_SHIFT_BIAS     = 17;
  localparam int ELEM_MAG_MAX         = 127;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    QUANT   = 2'd1,
    EMIT    = 2'd2
  } quant_state_t;

  // Subnormals and zero share the exponent of the smallest normal.
  function automatic logic [7:0] eff_exp(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : e;
  endfunction

endpackage

// File: rtl/mxint8_quant_elem.sv
// Combinational quantization of one binary32 element against the shared scale:
// align, optionally round nearest-even, clamp to +/-127, apply sign.
// MXINT8_QUANT_RNE_EN selects rounding; otherwise the element truncates toward zero.
module mxint8_quant_elem
  import mxint8_quantize_pkg::*;
(
  input  logic [FLOAT32_WIDTH-1:0] float32,
  input  logic [7:0]               scale,
  output logic [7:0]               q,
  output logic                     saturated
);

  logic [7:0]  exp_raw;
  logic [7:0]  eff;
  logic [23:0] sig;
  logic [9:0]  shamt;
  logic [23:0] trunc;
  logic        rnd_up;
  logic [8:0]  sum;
  logic [6:0]  mag;
  logic [7:0]  mag8;
`ifdef MXINT8_QUANT_RNE_EN
  logic [23:0] gmask;
  logic        guard;
  logic        sticky;
`endif

  // Align the significand to the block scale, round, clamp and sign.
  always_comb begin
    exp_raw = float32[30:23];
    eff     = eff_exp(exp_raw);
    sig     = {exp_raw != 8'd0, float32[22:0]};
    shamt   = {2'b00, scale} + 10'(QUANT_SHIFT_BIAS) - {2'b00, eff};
    trunc   = (shamt < 10'd25) ? (sig >> shamt[4:0]) : 24'd0;
`ifdef MXINT8_QUANT_RNE_EN
    gmask   = 24'd1 << (shamt[4:0] - 5'd1);
    guard   = (shamt < 10'd25) && ((sig & gmask) != 24'd0);
    sticky  = (sig & (gmask - 24'd1)) != 24'd0;
    rnd_up  = guard && (sticky || trunc[0]);
`else
    rnd_up  = 1'b0;
`endif
    sum       = {1'b0, trunc[7:0]} + {8'd0, rnd_up};
    saturated = (trunc[23:8] != 16'd0) || (sum > 9'(ELEM_MAG_MAX));
    mag       = saturated ? 7'(ELEM_MAG_MAX) : sum[6:0];
    mag8      = {1'b0, mag};
    q         = float32[31] ? (8'd0 - mag8) : mag8;
  end

endmodule

// File: rtl/mxint8_quantize.sv
// MXINT8 block quantizer: collects BLOCK_SIZE binary32 elements, derives the
// shared E8M0 scale from the largest effective exponent and emits the block.
// MXINT8_QUANT_RNE_EN enables round-to-nearest-even (default: truncate).
//
// state   | meaning
// COLLECT | accepting elements, tracking max exponent and NaN/nonzero flags
// QUANT   | one cycle: register scale, elements and flags
// EMIT    | o_valid high, outputs held until i_ready
module mxint8_quantize
  import mxint8_quantize_pkg::*;
#(
  parameter int BLOCK_SIZE           = DEF_BLOCK_SIZE,
  parameter int SCALE_WIDTH          = DEF_SCALE_WIDTH,
  parameter int MXINT8_ELEMENT_WIDTH = DEF_ELEMENT_WIDTH
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst,
  input  logic                                             i_valid,
  output logic                                             o_ready,
  input  logic [FLOAT32_WIDTH-1:0]                         i_float32,
  output logic                                             o_valid,
  input  logic                                             i_ready,
  output logic [SCALE_WIDTH-1:0]                           o_scale,
  output logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]  o_mxint8_elements,
  output logic                                             o_nan,
  output logic                                             o_saturated
);

  localparam int CNT_W = $clog2(BLOCK_SIZE);

  quant_state_t state, state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [FLOAT32_WIDTH-1:0] buffer [BLOCK_SIZE];
  logic [SCALE_WIDTH-1:0]   max_e;
  logic                     any_nan;
  logic                     any_nz;
  logic                     in_xfer;
  logic                     last_xfer;
  logic [7:0]               in_exp;
  logic [7:0]               in_eff;
  logic                     in_nz;
  logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0] q_vec;
  logic [BLOCK_SIZE-1:0]    sat_vec;

  assign in_xfer   = i_valid && o_ready;
  assign last_xfer = in_xfer && (cnt == CNT_W'(BLOCK_SIZE - 1));
  assign in_exp    = i_float32[30:23];
  assign in_eff    = eff_exp(in_exp);
  assign in_nz     = i_float32[30:0] != 31'd0;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= COLLECT;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (last_xfer) state_nxt = QUANT;
      QUANT:   state_nxt = EMIT;
      EMIT:    if (i_ready) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Handshake outputs follow the state directly.
  always_comb begin
    o_ready = (state == COLLECT);
    o_valid = (state == EMIT);
  end

  // Element buffer; contents are don't-care until fully rewritten.
  always_ff @(posedge i_clk) begin
    if (in_xfer) buffer[cnt] <= i_float32;
  end

  // Element count, running max exponent and sticky flags; cleared once consumed in QUANT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      max_e   <= '0;
      any_nan <= 1'b0;
      any_nz  <= 1'b0;
    end else if (in_xfer) begin
      cnt <= last_xfer ? '0 : cnt + 1'b1;
      if (in_nz && (SCALE_WIDTH'(in_eff) > max_e)) max_e <= SCALE_WIDTH'(in_eff);
      if (in_exp == 8'hFF) any_nan <= 1'b1;
      if (in_nz) any_nz <= 1'b1;
    end else if (state == QUANT) begin
      max_e   <= '0;
      any_nan <= 1'b0;
      any_nz  <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_elem
    mxint8_quant_elem u_elem (
      .float32   (buffer[gi]),
      .scale     (max_e),
      .q         (q_vec[gi]),
      .saturated (sat_vec[gi])
    );
  end

  // Result registers load in QUANT and hold through EMIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_scale           <= '0;
      o_mxint8_elements <= '0;
      o_nan             <= 1'b0;
      o_saturated       <= 1'b0;
    end else if (state == QUANT) begin
      if (any_nan) begin
        o_scale           <= '1;
        o_mxint8_elements <= '0;
        o_nan             <= 1'b1;
        o_saturated       <= 1'b0;
      end else if (!any_nz) begin
        o_scale           <= '0;
        o_mxint8_elements <= '0;
        o_nan             <= 1'b0;
        o_saturated       <= 1'b0;
      end else begin
        o_scale           <= max_e;
        o_mxint8_elements <= q_vec;
        o_nan             <= 1'b0;
        o_saturated       <= |sat_vec;
      end
    end
  end

endmodule

// File: tb/tb_mxint8_quantize.sv
// Scoreboard bench for mxint8_quantize: directed blocks push hand-computed
// expectations; a negedge monitor compares every presented block.
// Expectations track MXINT8_QUANT_RNE_EN.
module tb_mxint8_quantize;

  localparam int N = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_float32;
  logic              o_valid;
  logic              i_ready;
  logic [7:0]        o_scale;
  logic [N-1:0][7:0] o_elems;
  logic              o_nan;
  logic              o_saturated;

  typedef struct packed {
    logic [7:0]     scale;
    logic [N*8-1:0] elems;
    logic           nan;
    logic           sat;
  } exp_t;

  exp_t        sb[$];
  int          errors   = 0;
  int          checks   = 0;
  int          pushed   = 0;
  int          received = 0;
  logic [31:0] blk [N];
  logic [N*8-1:0] ev;

`ifdef MXINT8_QUANT_RNE_EN
  localparam logic [7:0] E1_RND   = 8'h41;
  localparam logic       SAT_FULL = 1'b1;
`else
  localparam logic [7:0] E1_RND   = 8'h40;
  localparam logic       SAT_FULL = 1'b0;
`endif

  mxint8_quantize dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_valid           (i_valid),
    .o_ready           (o_ready),
    .i_float32         (i_float32),
    .o_valid           (o_valid),
    .i_ready           (i_ready),
    .o_scale           (o_scale),
    .o_mxint8_elements (o_elems),
    .o_nan             (o_nan),
    .o_saturated       (o_saturated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*8-1:0] act, input logic [N*8-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] s, input logic [N*8-1:0] e, input logic n, input logic sat);
    exp_t x;
    x.scale = s; x.elems = e; x.nan = n; x.sat = sat;
    sb.push_back(x);
    pushed++;
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < N; i++) blk[i] = v;
  endtask

  // Sends the first n words of blk, one per cycle while o_ready allows.
  task automatic send(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      w = 0;
      while (!o_ready && w < 200) begin
        i_valid = 1'b0;
        @(negedge clk);
        w++;
      end
      if (!o_ready) begin
        checks++; errors++;
        $display("FAIL o_ready_timeout actual=0 required=1");
      end
      i_valid   = 1'b1;
      i_float32 = blk[i];
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (sb.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sb.size());
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_o_valid"}, N*8'(o_valid), '0);
    chk({tag, "_o_ready"}, N*8'(o_ready), N*8'(1));
    chk({tag, "_o_scale"}, N*8'(o_scale), '0);
    chk({tag, "_elements"}, o_elems, '0);
    chk({tag, "_o_nan"}, N*8'(o_nan), '0);
    chk({tag, "_o_saturated"}, N*8'(o_saturated), '0);
  endtask

  // Monitor: compare every presented block against the scoreboard head, pop on accept.
  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_block actual_scale=%0h required=none", o_scale);
      end else begin
        chk("o_scale", N*8'(o_scale), N*8'(sb[0].scale));
        chk("elements", o_elems, sb[0].elems);
        chk("o_nan", N*8'(o_nan), N*8'(sb[0].nan));
        chk("o_saturated", N*8'(o_saturated), N*8'(sb[0].sat));
        chk("o_ready_in_emit", N*8'(o_ready), '0);
        if (i_ready) begin
          void'(sb.pop_front());
          received++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1; i_valid = 1'b0; i_float32 = '0; i_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // 32 x 1.0
    fill(32'h3F800000);
    push(8'h7F, {N{8'h40}}, 1'b0, 1'b0);
    send(N);

    // -2.0 then 0.5s
    fill(32'h3F000000); blk[0] = 32'hC0000000;
    push(8'h80, {{(N-1){8'h10}}, 8'hC0}, 1'b0, 1'b0);
    send(N);

    // 1.0, 1.01171875, zeros: rounding of elem1
    fill(32'h0); blk[0] = 32'h3F800000; blk[1] = 32'h3F818000;
    ev = '0; ev[7:0] = 8'h40; ev[15:8] = E1_RND;
    push(8'h7F, ev, 1'b0, 1'b0);
    send(N);

    // 0x3FFFFFFF, zeros: round-up to 128 clamps
    fill(32'h0); blk[0] = 32'h3FFFFFFF;
    ev = '0; ev[7:0] = 8'h7F;
    push(8'h7F, ev, 1'b0, SAT_FULL);
    send(N);

    // NaN at elem5
    fill(32'h3F800000); blk[5] = 32'h7FC00000;
    push(8'hFF, '0, 1'b1, 1'b0);
    send(N);

    // -1.0 then 1.0s
    fill(32'h3F800000); blk[0] = 32'hBF800000;
    push(8'h7F, {{(N-1){8'h40}}, 8'hC0}, 1'b0, 1'b0);
    send(N);

    // all zeros including -0
    fill(32'h0); blk[3] = 32'h80000000;
    push(8'h00, '0, 1'b0, 1'b0);
    send(N);

    // backpressure: i_ready low for 3 cycles while the block is presented
    wait_drain();
    @(posedge clk); #1 i_ready = 1'b0;
    fill(32'h3F800000);
    push(8'h7F, {N{8'h40}}, 1'b0, 1'b0);
    send(N);
    w = 0;
    while (!o_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!o_valid) begin
      checks++; errors++;
      $display("FAIL o_valid_timeout actual=0 required=1");
    end
    repeat (3) @(posedge clk);
    #1 i_ready = 1'b1;
    wait_drain();

    // reset after 10 inputs, coinciding with an 11th transfer, then a clean block
    fill(32'h40000000);
    send(10);
    i_valid = 1'b1; i_float32 = 32'h40000000; rst = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; rst = 1'b0;
    check_reset_state("mid_block_reset");
    fill(32'h3F800000);
    push(8'h7F, {N{8'h40}}, 1'b0, 1'b0);
    send(N);
    wait_drain();

    repeat (10) @(negedge clk);
    chk("blocks_received", N*8'(received), N*8'(pushed));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
